// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte engine: FSM state encoding, the number
// of SCK edges in one byte and the level MOSI rests at between transfers.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spiState_e;

    // Eight bits, each with one rising and one falling SCK edge.
    localparam int SPI_EDGES = 16;
    localparam int EDGE_W    = $clog2(SPI_EDGES);

    // SD cards expect MOSI high whenever no command is being shifted.
    localparam logic MOSI_IDLE = 1'b1;

    // Used to size the half-period counter for the larger of two settings.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Programmable half-period counter for the SPI engine. Counts 0..halfM1_i
// while enabled and raises tick_o for the single cycle the count wraps.
// clear_i restarts the count so every byte begins with a full half-period.
module spi_half_tick
    import spi_pkg::*;
#(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] halfM1_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wrap;

    assign wrap   = (count_q == halfM1_i);
    assign tick_o = enable_i & wrap;

    // Next count: restart on clear, wrap at the programmed half-period.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (wrap) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine, MSB first, no chip select. Takes one byte per
// tx_dv/tx_ready handshake, shifts it out on mosi while sampling miso on the
// rising SCK edges, and returns the received byte with a one-cycle rx_dv.
// Optional feature macro: SPI_SLOW_CLK_EN adds the 'slow' input, which picks
// SLOW_HALF_BIT as the half-period for the next byte (SD card init phase).
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2
`ifdef SPI_SLOW_CLK_EN
    ,
    parameter int SLOW_HALF_BIT = 64
`endif
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_byte,
    input  logic       tx_dv,
    output logic       tx_ready,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi,
`ifdef SPI_SLOW_CLK_EN
    input  logic       slow,
`endif
    input  logic       miso
);

`ifdef SPI_SLOW_CLK_EN
    localparam int HALF_MAX = maxInt(CLKS_PER_HALF_BIT, SLOW_HALF_BIT);
`else
    localparam int HALF_MAX = CLKS_PER_HALF_BIT;
`endif
    localparam int CNT_W = $clog2(HALF_MAX);

    localparam logic [CNT_W-1:0]  FAST_M1   = CNT_W'(CLKS_PER_HALF_BIT - 1);
`ifdef SPI_SLOW_CLK_EN
    localparam logic [CNT_W-1:0]  SLOW_M1   = CNT_W'(SLOW_HALF_BIT - 1);
`endif
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(SPI_EDGES - 1);

    spiState_e         state_q, state_d;
    logic              sck_q, sck_d;
    logic              txReady_q, txReady_d;
    logic              rxDv_q, rxDv_d;
    logic [7:0]        rxByte_q, rxByte_d;
    logic [7:0]        txShift_q, txShift_d;
    logic [7:0]        rxShift_q, rxShift_d;
    logic [EDGE_W-1:0] edgeCnt_q, edgeCnt_d;
    logic [CNT_W-1:0]  halfM1_q, halfM1_d;
    logic              accept;
    logic              tick;
    logic [CNT_W-1:0]  halfSel;

    assign accept = tx_dv & txReady_q;

`ifdef SPI_SLOW_CLK_EN
    assign halfSel = slow ? SLOW_M1 : FAST_M1;
`else
    assign halfSel = FAST_M1;
`endif

    // MOSI is the top of the transmit shift register; ones are shifted in
    // behind the data so the line returns high after the last bit.
    assign mosi     = txShift_q[7];
    assign sck      = sck_q;
    assign tx_ready = txReady_q;
    assign rx_dv    = rxDv_q;
    assign rx_byte  = rxByte_q;

    spi_half_tick #(
        .CNT_W(CNT_W)
    ) u_half_tick (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (accept),
        .enable_i (state_q == SHIFT),
        .halfM1_i (halfM1_q),
        .tick_o   (tick)
    );

    // Next-state logic: accept a byte, toggle SCK on each half-period tick,
    // sample on rising edges, advance MOSI on falling edges, then report.
    always_comb begin
        state_d   = state_q;
        sck_d     = sck_q;
        txReady_d = txReady_q;
        rxDv_d    = 1'b0;
        rxByte_d  = rxByte_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        edgeCnt_d = edgeCnt_q;
        halfM1_d  = halfM1_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    txShift_d = tx_byte;
                    rxShift_d = '0;
                    edgeCnt_d = '0;
                    halfM1_d  = halfSel;
                    txReady_d = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rxShift_d = {rxShift_q[6:0], miso};
                    end else begin
                        txShift_d = {txShift_q[6:0], MOSI_IDLE};
                    end
                    if (edgeCnt_q == EDGE_LAST) begin
                        edgeCnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        edgeCnt_d = edgeCnt_q + EDGE_W'(1);
                    end
                end
            end
            DONE: begin
                rxByte_d  = rxShift_q;
                rxDv_d    = 1'b1;
                txReady_d = 1'b1;
                txShift_d = {8{MOSI_IDLE}};
                sck_d     = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            sck_q     <= 1'b0;
            txReady_q <= 1'b1;
            rxDv_q    <= 1'b0;
            rxByte_q  <= 8'h00;
            txShift_q <= {8{MOSI_IDLE}};
            rxShift_q <= 8'h00;
            edgeCnt_q <= '0;
            halfM1_q  <= '0;
        end else begin
            state_q   <= state_d;
            sck_q     <= sck_d;
            txReady_q <= txReady_d;
            rxDv_q    <= rxDv_d;
            rxByte_q  <= rxByte_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            edgeCnt_q <= edgeCnt_d;
            halfM1_q  <= halfM1_d;
        end
    end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed testbench for spi_byte_engine: reset, loopback, fixed miso,
// back-to-back bytes, ignored mid-byte requests and (with SPI_SLOW_CLK_EN)
// the slow SCK setting. Expected values are hand-computed constants.
module tb_spi_byte_engine;

    logic       clk;
    logic       resetn;
    logic [7:0] tx_byte;
    logic       tx_dv;
    logic       tx_ready;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       sck;
    logic       mosi;
    logic       miso;
`ifdef SPI_SLOW_CLK_EN
    logic       slow;
`endif

    logic       loopback;
    logic       misoDrv;

    int         checkCount;
    int         errorCount;

    // Results of the most recent applyStimulus call.
    int         dvCycle;
    int         firstRise;
    int         riseCnt;
    logic [7:0] mosiBits;

    int         extraDv;
    int         extraRise;
    logic       prevSck;

    assign miso = loopback ? mosi : misoDrv;

    spi_byte_engine dut (
        .clk      (clk),
        .resetn   (resetn),
        .tx_byte  (tx_byte),
        .tx_dv    (tx_dv),
        .tx_ready (tx_ready),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .sck      (sck),
        .mosi     (mosi),
`ifdef SPI_SLOW_CLK_EN
        .slow     (slow),
`endif
        .miso     (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so a stuck DUT can never hang the run.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one byte in the current cycle (called just after a negedge with
    // tx_ready high) and follows it until rx_dv. Counts are in cycles after
    // the accept cycle; injectAt>0 pulses tx_dv with 8'hFF at that cycle.
    task automatic applyStimulus(input logic [7:0] txb, input int injectAt,
                                 input int bound);
        dvCycle   = -1;
        firstRise = 0;
        riseCnt   = 0;
        mosiBits  = 8'h00;
        prevSck   = sck;
        tx_byte   = txb;
        tx_dv     = 1'b1;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            if (n == 1) tx_dv = 1'b0;
            if (injectAt > 0 && n == injectAt) begin
                tx_byte = 8'hFF;
                tx_dv   = 1'b1;
            end else if (injectAt > 0 && n == injectAt + 1) begin
                tx_dv = 1'b0;
            end
            if (sck && !prevSck) begin
                riseCnt++;
                mosiBits = {mosiBits[6:0], mosi};
                if (firstRise == 0) firstRise = n;
            end
            prevSck = sck;
            if (rx_dv) begin
                dvCycle = n;
                break;
            end
        end
        tx_dv = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        resetn     = 1'b0;
        tx_dv      = 1'b0;
        tx_byte    = 8'h00;
        loopback   = 1'b1;
        misoDrv    = 1'b0;
`ifdef SPI_SLOW_CLK_EN
        slow       = 1'b0;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_sck", 32'(sck), 32'h0);
        checkOutput("rst_mosi", 32'(mosi), 32'h1);
        checkOutput("rst_ready", 32'(tx_ready), 32'h1);
        checkOutput("rst_rxdv", 32'(rx_dv), 32'h0);
        checkOutput("rst_rxbyte", 32'(rx_byte), 32'h00);
        resetn = 1'b1;
        @(negedge clk);

        // Loopback A5.
        applyStimulus(8'hA5, 0, 100);
        checkOutput("lb_first_rise", 32'(firstRise), 32'd3);
        checkOutput("lb_rises", 32'(riseCnt), 32'd8);
        checkOutput("lb_dv_cycle", 32'(dvCycle), 32'd34);
        checkOutput("lb_rx_byte", 32'(rx_byte), 32'hA5);
        checkOutput("lb_mosi_bits", 32'(mosiBits), 32'hA5);
        checkOutput("lb_ready_at_dv", 32'(tx_ready), 32'h1);
        @(negedge clk);
        checkOutput("lb_dv_pulse", 32'(rx_dv), 32'h0);
        checkOutput("lb_rx_held", 32'(rx_byte), 32'hA5);
        checkOutput("lb_idle_mosi", 32'(mosi), 32'h1);
        checkOutput("lb_idle_sck", 32'(sck), 32'h0);

        // Reset asserted in the middle of a byte.
        tx_byte = 8'h96;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (11) @(negedge clk);
        checkOutput("mid_busy", 32'(tx_ready), 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_sck", 32'(sck), 32'h0);
        checkOutput("mid_rst_mosi", 32'(mosi), 32'h1);
        checkOutput("mid_rst_ready", 32'(tx_ready), 32'h1);
        checkOutput("mid_rst_rxdv", 32'(rx_dv), 32'h0);
        checkOutput("mid_rst_rxbyte", 32'(rx_byte), 32'h00);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_rst_sck", 32'(sck), 32'h0);

        // miso held high, transmit 00.
        loopback = 1'b0;
        misoDrv  = 1'b1;
        applyStimulus(8'h00, 0, 100);
        checkOutput("ones_mosi_bits", 32'(mosiBits), 32'h00);
        checkOutput("ones_rx_byte", 32'(rx_byte), 32'hFF);
        checkOutput("ones_dv_cycle", 32'(dvCycle), 32'd34);
        @(negedge clk);
        checkOutput("ones_idle_mosi", 32'(mosi), 32'h1);

        // Back-to-back 3C then C3, second request in the rx_dv cycle.
        loopback = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'h3C, 0, 100);
        checkOutput("b2b_dv1", 32'(dvCycle), 32'd34);
        checkOutput("b2b_rx1", 32'(rx_byte), 32'h3C);
        checkOutput("b2b_ready1", 32'(tx_ready), 32'h1);
        applyStimulus(8'hC3, 0, 100);
        checkOutput("b2b_first_rise2", 32'(firstRise), 32'd3);
        checkOutput("b2b_rises2", 32'(riseCnt), 32'd8);
        checkOutput("b2b_dv2", 32'(dvCycle), 32'd34);
        checkOutput("b2b_rx2", 32'(rx_byte), 32'hC3);

        // Request while busy is ignored.
        repeat (3) @(negedge clk);
        applyStimulus(8'h5A, 10, 100);
        checkOutput("ign_dv_cycle", 32'(dvCycle), 32'd34);
        checkOutput("ign_rx_byte", 32'(rx_byte), 32'h5A);
        extraDv   = 0;
        extraRise = 0;
        prevSck   = sck;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rx_dv) extraDv++;
            if (sck && !prevSck) extraRise++;
            prevSck = sck;
        end
        checkOutput("ign_extra_dv", 32'(extraDv), 32'd0);
        checkOutput("ign_extra_rise", 32'(extraRise), 32'd0);
        checkOutput("ign_rx_held", 32'(rx_byte), 32'h5A);

`ifdef SPI_SLOW_CLK_EN
        // Slow SCK for SD initialisation, then back to the fast rate.
        slow = 1'b1;
        applyStimulus(8'h69, 0, 2000);
        checkOutput("slow_first_rise", 32'(firstRise), 32'd65);
        checkOutput("slow_dv_cycle", 32'(dvCycle), 32'd1026);
        checkOutput("slow_rx_byte", 32'(rx_byte), 32'h69);
        slow = 1'b0;
        @(negedge clk);
        applyStimulus(8'h81, 0, 2000);
        checkOutput("fast_dv_cycle", 32'(dvCycle), 32'd34);
        checkOutput("fast_rx_byte", 32'(rx_byte), 32'h81);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
